// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - RV32I load/store constants, register type and LSU state enum
package RV32Consts;

   typedef logic [31:0] IntReg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   // Undefined width codes are rejected the same way as misaligned addresses.
   function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      if (we) begin
         case (f3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = ~a[0];
            F3_SW:   ok = (a == 2'b00);
            default: ok = 1'b0;
         endcase
      end else begin
         case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~a[0];
            F3_LW:         ok = (a == 2'b00);
            default:       ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// rtl/load_store_unit_lane_align.sv - store byte-lane steering and load extraction/extension
module lsu_lane_align
   import RV32Consts::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  IntReg       wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_lanes,
   output IntReg       load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      wstrb       = 4'b0000;
      wdata_lanes = 32'h0;
      if (we) begin
         case (funct3)
            F3_SB: begin
               wstrb       = 4'b0001 << addr_lo;
               wdata_lanes = {4{wdata[7:0]}};
            end
            F3_SH: begin
               wstrb       = 4'b0011 << {addr_lo[1], 1'b0};
               wdata_lanes = {2{wdata[15:0]}};
            end
            F3_SW: begin
               wstrb       = 4'b1111;
               wdata_lanes = wdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_v    = rdata[{addr_lo, 3'b000} +: 8];
      half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      load_data = 32'h0;
      case (funct3)
         F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
         F3_LH:   load_data = {{16{half_v[15]}}, half_v};
         F3_LW:   load_data = rdata;
         F3_LBU:  load_data = {24'h0, byte_v};
         F3_LHU:  load_data = {16'h0, half_v};
         default: load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store unit with bus timeout
module load_store_unit
   import RV32Consts::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  IntReg       req_wdata,
   input  logic [4:0]  req_rd,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic [4:0]  rd_addr,
   output IntReg       rd_data,
   output logic        rd_en,
   output logic        done,
   output logic        misaligned,
   output logic        fault
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic        misaligned_q, misaligned_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   IntReg       wdata_q;
   logic [4:0]  rd_q;
   IntReg       rd_data_q;
   logic        capture_en;
   logic        load_en;
   IntReg       load_data;

   lsu_lane_align u_align (
      .we          (we_q),
      .funct3      (funct3_q),
      .addr_lo     (addr_q[1:0]),
      .wdata       (wdata_q),
      .rdata       (bus_rdata),
      .wstrb       (bus_wstrb),
      .wdata_lanes (bus_wdata),
      .load_data   (load_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fault_d      = 1'b0;
      misaligned_d = 1'b0;
      capture_en   = 1'b0;
      load_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (is_legal(req_we, req_funct3, req_addr[1:0])) begin
                  capture_en = 1'b1;
                  cnt_d      = '0;
                  state_d    = REQ;
               end else begin
                  misaligned_d = 1'b1;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            // A handshake on the last allowed cycle still completes the access.
            if (bus_ready) begin
               state_d = we_q ? RESP : WAIT_R;
            end else if (cnt_q == LIMIT) begin
               fault_d = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_R: begin
            cnt_d = cnt_q + CW'(1);
            if (bus_rvalid) begin
               load_en = 1'b1;
               state_d = RESP;
            end else if (cnt_q == LIMIT) begin
               fault_d = 1'b1;
               state_d = IDLE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fault_q      <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fault_q      <= fault_d;
         misaligned_q <= misaligned_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         funct3_q  <= 3'd0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         rd_q      <= 5'd0;
         rd_data_q <= 32'h0;
      end else begin
         if (capture_en) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
         end
         if (load_en) begin
            rd_data_q <= load_data;
         end
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign bus_valid  = (state_q == REQ);
   assign bus_we     = we_q;
   assign bus_addr   = {addr_q[31:2], 2'b00};
   assign done       = (state_q == RESP);
   assign rd_en      = (state_q == RESP) && !we_q && (rd_q != 5'd0);
   assign rd_addr    = rd_q;
   assign rd_data    = rd_data_q;
   assign misaligned = misaligned_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

   localparam int TO = 8;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_en;
   logic        done;
   logic        misaligned;
   logic        fault;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wstrb  (bus_wstrb),
      .bus_wdata  (bus_wdata),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_en      (rd_en),
      .done       (done),
      .misaligned (misaligned),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Access size in bytes; 0 marks an undefined width code.
   function automatic int size_of(input logic we, input logic [2:0] f3);
      if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int n;
      n = size_of(we, f3);
      return (n != 0) && ((int'(a[1:0]) % n) == 0);
   endfunction

   function automatic logic [3:0] m_wstrb(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int n;
      if (!we) return 4'h0;
      n = size_of(we, f3);
      return 4'(((1 << n) - 1) << int'(a[1:0]));
   endfunction

   function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int n;
      r = 32'h0;
      if (!we) return r;
      n = size_of(we, f3);
      for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
      logic [31:0] v;
      int n;
      n = size_of(1'b0, f3);
      v = rdat >> (8 * int'(a[1:0]));
      if (n < 4) begin
         v = v & ((32'h1 << (8 * n)) - 32'h1);
         if (f3 < 3'd3 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      end
      return v;
   endfunction

   task automatic expect_fault();
      req_valid = 1'b0;
      check("fault_pulse", 32'(fault), 32'h1);
      check("fault_bus_valid", 32'(bus_valid), 32'h0);
      check("fault_rd_en", 32'(rd_en), 32'h0);
      check("fault_done", 32'(done), 32'h0);
      check("fault_req_ready", 32'(req_ready), 32'h1);
   endtask

   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int rdly,
                          input int vdly, input logic [31:0] rdat, input logic noise);
      int waited;
      int j;
      logic hit;
      check("idle_ready", 32'(req_ready), 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_rd     = rd;
      @(negedge clk);
      req_valid = 1'b0;
      if (!m_legal(we, f3, addr)) begin
         check("misaligned_pulse", 32'(misaligned), 32'h1);
         check("misaligned_no_bus", 32'(bus_valid), 32'h0);
         check("misaligned_ready", 32'(req_ready), 32'h1);
         return;
      end
      check("legal_no_misaligned", 32'(misaligned), 32'h0);
      waited = 0;
      hit    = 1'b0;
      while (!hit && waited < TO) begin
         check("req_bus_valid", 32'(bus_valid), 32'h1);
         check("req_bus_addr", bus_addr, {addr[31:2], 2'b00});
         check("req_bus_we", 32'(bus_we), 32'(we));
         check("req_bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb(we, f3, addr)));
         check("req_bus_wdata", bus_wdata, m_wdata(we, f3, wd));
         check("busy_req_ready", 32'(req_ready), 32'h0);
         bus_ready = (waited == rdly);
         if (noise) begin
            bus_rvalid = 1'($urandom);
            req_valid  = 1'($urandom);
            req_addr   = $urandom;
         end
         hit = bus_ready;
         @(negedge clk);
         bus_ready  = 1'b0;
         bus_rvalid = 1'b0;
         waited++;
      end
      if (!hit) begin
         expect_fault();
         return;
      end
      if (!we) begin
         hit = 1'b0;
         j   = 0;
         while (!hit && waited < TO) begin
            check("wait_bus_valid", 32'(bus_valid), 32'h0);
            check("wait_req_ready", 32'(req_ready), 32'h0);
            bus_rvalid = (j == vdly);
            bus_rdata  = bus_rvalid ? rdat : $urandom;
            if (noise) req_valid = 1'($urandom);
            hit = bus_rvalid;
            @(negedge clk);
            bus_rvalid = 1'b0;
            waited++;
            j++;
         end
         if (!hit) begin
            expect_fault();
            return;
         end
      end
      req_valid = 1'b0;
      check("resp_done", 32'(done), 32'h1);
      check("resp_rd_en", 32'(rd_en), 32'(!we && rd != 5'd0));
      if (!we && rd != 5'd0) begin
         check("resp_rd_addr", 32'(rd_addr), 32'(rd));
         check("resp_rd_data", rd_data, m_load(f3, addr, rdat));
      end
      check("resp_no_fault", 32'(fault), 32'h0);
      check("resp_no_misaligned", 32'(misaligned), 32'h0);
      @(negedge clk);
      check("after_done", 32'(done), 32'h0);
      check("after_rd_en", 32'(rd_en), 32'h0);
      check("after_ready", 32'(req_ready), 32'h1);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_bus_valid"}, 32'(bus_valid), 32'h0);
      check({pfx, "_rd_en"}, 32'(rd_en), 32'h0);
      check({pfx, "_done"}, 32'(done), 32'h0);
      check({pfx, "_misaligned"}, 32'(misaligned), 32'h0);
      check({pfx, "_fault"}, 32'(fault), 32'h0);
      check({pfx, "_rd_data"}, rd_data, 32'h0);
      check({pfx, "_rd_addr"}, 32'(rd_addr), 32'h0);
      check({pfx, "_bus_addr"}, bus_addr, 32'h0);
      check({pfx, "_bus_wdata"}, bus_wdata, 32'h0);
      check({pfx, "_req_ready"}, 32'(req_ready), 32'h1);
   endtask

   initial begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      int          r_rdly;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_rd     = 5'd0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      #1;
      check("first_cycle_ready", 32'(req_ready), 32'h1);
      @(negedge clk);

      run_txn(1'b0, 3'd0, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 32'h80FF_FFFF, 1'b0);
      run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 5'd9, 4, 0, 32'h0, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_3001, 32'h0, 5'd3, 0, 0, 32'h0, 1'b0);
      run_txn(1'b0, 3'd5, 32'h0000_3002, 32'h0, 5'd4, 1, 1, 32'hABCD_1234, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_5000, 32'h0, 5'd6, 20, 0, 32'h0, 1'b0);
      run_txn(1'b0, 3'd2, 32'h0000_6000, 32'h0, 5'd0, 1, 2, 32'h1234_5678, 1'b1);
      run_txn(1'b1, 3'd2, 32'h0000_7004, 32'hCAFE_F00D, 5'd1, 7, 0, 32'h0, 1'b0);
      run_txn(1'b0, 3'd0, 32'h0000_7001, 32'h0, 5'd2, 2, 4, 32'h1122_3344, 1'b0);
      run_txn(1'b0, 3'd1, 32'h0000_7002, 32'h0, 5'd2, 3, 4, 32'h5566_7788, 1'b0);
      run_txn(1'b1, 3'd3, 32'h0000_8000, 32'h0, 5'd2, 0, 0, 32'h0, 1'b0);
      run_txn(1'b0, 3'd6, 32'h0000_8000, 32'h0, 5'd2, 0, 0, 32'h0, 1'b0);
      run_txn(1'b1, 3'd0, 32'h0000_9003, 32'h0000_00A5, 5'd2, 0, 0, 32'h0, 1'b0);

      for (int i = 0; i < 120; i++) begin
         r_we   = 1'($urandom);
         r_f3   = 3'($urandom);
         r_addr = $urandom;
         if ($urandom_range(1, 0) == 1) r_addr[1:0] = 2'b00;
         r_rdly = ($urandom_range(7, 0) == 0) ? 9 : int'($urandom_range(3, 0));
         run_txn(r_we, r_f3, r_addr, $urandom, 5'($urandom), r_rdly,
                 int'($urandom_range(2, 0)), $urandom, 1'($urandom));
      end

      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_4000;
      req_rd     = 5'd7;
      @(negedge clk);
      req_valid = 1'b0;
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      check("rst_pre_wait_ready", 32'(req_ready), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      rst_n      = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_rd_en", 32'(rd_en), 32'h0);
         check("post_rst_done", 32'(done), 32'h0);
         check("post_rst_fault", 32'(fault), 32'h0);
         check("post_rst_ready", 32'(req_ready), 32'h1);
      end
      bus_rvalid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
